// File: rtl/dpr_pkg.sv
// rtl/dpr_pkg.sv - shared constants for the dual-port RAM port-2 arbiter
package dpr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/dpr_arb_pick.sv
// rtl/dpr_arb_pick.sv - combinational grant selection between two requesters
module dpr_arb_pick
  import dpr_pkg::*;
#(
  parameter int PRIO = PRIO_RR
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic g
);

  always_comb begin
    valid = req0 | req1;
    g     = ~req0;
    // On a tie in round-robin mode the requester that did not win last time goes next.
    if (PRIO != PRIO_FIXED && req0 && req1) begin
      g = ~last;
    end
  end

endmodule

// File: rtl/dpr_arb.sv
// rtl/dpr_arb.sv - two-requester arbiter/sequencer for RAM port 2
module dpr_arb
  import dpr_pkg::*;
#(
  parameter int AW   = 14,
  parameter int PRIO = PRIO_RR
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] a0,
  input  logic [7:0]    d0,
  output logic [7:0]    q0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [7:0]    d1,
  output logic [7:0]    q1,
  output logic          ack1,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_di,
  input  logic [7:0]    ram_do,
  output logic          busy
);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          ram_ce_q, ram_ce_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]    ram_di_q, ram_di_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [7:0]    q0_q, q0_d;
  logic [7:0]    q1_q, q1_d;
  logic          busy_q, busy_d;

  logic pick_valid;
  logic pick_g;

  dpr_arb_pick #(.PRIO(PRIO)) u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .valid (pick_valid),
    .g     (pick_g)
  );

  // last_q doubles as the active grant from the grant edge until the next IDLE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    ram_ce_d = ram_ce_q;
    ram_we_d = ram_we_q;
    ram_a_d  = ram_a_q;
    ram_di_d = ram_di_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    q0_d     = q0_q;
    q1_d     = q1_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ram_ce_d = 1'b1;
          ram_a_d  = pick_g ? a1 : a0;
          ram_di_d = pick_g ? d1 : d0;
          ram_we_d = ~(pick_g ? we1 : we0);
          last_d   = pick_g;
          state_d  = ST_ACC;
        end
      end
      ST_ACC: begin
        ram_ce_d = 1'b0;
        ram_we_d = 1'b1;
        if (!ram_we_q) begin
          ack0_d  = ~last_q;
          ack1_d  = last_q;
          state_d = ST_ACK;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (last_q) begin
          q1_d = ram_do;
        end else begin
          q0_d = ram_do;
        end
        ack0_d  = ~last_q;
        ack1_d  = last_q;
        state_d = ST_ACK;
      end
      default: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      ram_ce_q <= 1'b0;
      ram_we_q <= 1'b1;
      ram_a_q  <= '0;
      ram_di_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      q0_q     <= '0;
      q1_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      ram_ce_q <= ram_ce_d;
      ram_we_q <= ram_we_d;
      ram_a_q  <= ram_a_d;
      ram_di_q <= ram_di_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      q0_q     <= q0_d;
      q1_q     <= q1_d;
      busy_q   <= busy_d;
    end
  end

  assign ram_ce = ram_ce_q;
  assign ram_we = ram_we_q;
  assign ram_a  = ram_a_q;
  assign ram_di = ram_di_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign q0     = q0_q;
  assign q1     = q1_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_dpr_arb.sv
// tb/tb_dpr_arb.sv - directed self-checking bench for dpr_arb
module tb_dpr_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [13:0] a0 = 0, a1 = 0;
  logic [7:0]  d0 = 0, d1 = 0;
  logic [7:0]  q0, q1;
  logic        ack0, ack1;
  logic        ram_ce, ram_we, busy;
  logic [13:0] ram_a;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do = 8'h00;

  logic        f_req0 = 0, f_req1 = 0;
  logic [7:0]  f_q0, f_q1;
  logic        f_ack0, f_ack1, f_ce, f_we, f_busy;
  logic [13:0] f_a;
  logic [7:0]  f_di;
  logic [7:0]  f_do = 8'h00;

  logic [7:0]  mem [0:16383];

  int n_chk = 0;
  int n_pass = 0;

  int          r_ce_cnt, r_ack_cyc, r_who, r_both;
  logic        r_we;
  logic [13:0] r_a;
  logic [7:0]  r_di, r_q;

  always #5 clock = ~clock;

  dpr_arb #(.AW(14), .PRIO(0)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .a0(a0), .d0(d0), .q0(q0), .ack0(ack0),
    .req1(req1), .we1(we1), .a1(a1), .d1(d1), .q1(q1), .ack1(ack1),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do), .busy(busy)
  );

  dpr_arb #(.AW(14), .PRIO(1)) dut_fx (
    .clock(clock), .reset(reset),
    .req0(f_req0), .we0(1'b1), .a0(14'h0001), .d0(8'hA0), .q0(f_q0), .ack0(f_ack0),
    .req1(f_req1), .we1(1'b1), .a1(14'h0002), .d1(8'hB0), .q1(f_q1), .ack1(f_ack1),
    .ram_ce(f_ce), .ram_we(f_we), .ram_a(f_a), .ram_di(f_di),
    .ram_do(f_do), .busy(f_busy)
  );

  // RAM port-2 model: registered read data, updated only on a ce cycle.
  always @(posedge clock) begin
    if (ram_ce) begin
      if (!ram_we) mem[ram_a] <= ram_di;
      ram_do <= mem[ram_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Issue one transfer from requester r and observe it until its ack (bounded).
  task automatic xfer(input int r, input logic we, input logic [13:0] a, input logic [7:0] d);
    r_ce_cnt = 0; r_ack_cyc = 0; r_who = -1; r_both = 0;
    r_we = 1'bx; r_a = 'x; r_di = 'x; r_q = 'x;
    if (r == 0) begin req0 = 1; we0 = we; a0 = a; d0 = d; end
    else begin req1 = 1; we1 = we; a1 = a; d1 = d; end
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      if (ram_ce) begin
        r_ce_cnt++; r_we = ram_we; r_a = ram_a; r_di = ram_di;
      end
      if (ack0 && ack1) r_both = 1;
      if (ack0 || ack1) begin
        r_ack_cyc = n; r_who = ack1 ? 1 : 0; r_q = ack1 ? q1 : q0;
        break;
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clock);
    chk("ack_one_cycle", {30'd0, ack0, ack1}, 32'd0);
    chk("idle_after_ack", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seq[4];
    int ng, both, wide;
    logic p0, p1;
    int n0, a1cnt, lat, bad;

    repeat (3) @(negedge clock);
    chk("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd1);
    chk("rst_ram_a", {18'd0, ram_a}, 32'd0);
    chk("rst_ram_di", {24'd0, ram_di}, 32'd0);
    chk("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    chk("rst_q", {16'd0, q0, q1}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1;
    @(negedge clock);

    // Single write from requester 0.
    xfer(0, 1'b1, 14'h0123, 8'h5A);
    chk("wr_ce_cycles", r_ce_cnt, 1);
    chk("wr_ram_we", {31'd0, r_we}, 32'd0);
    chk("wr_ram_a", {18'd0, r_a}, 32'h0123);
    chk("wr_ram_di", {24'd0, r_di}, 32'h5A);
    chk("wr_ack_cycle", r_ack_cyc, 2);
    chk("wr_ack_who", r_who, 0);
    chk("wr_both", r_both, 0);

    // Read-back from requester 1.
    xfer(1, 1'b0, 14'h0123, 8'h00);
    chk("rd_ce_cycles", r_ce_cnt, 1);
    chk("rd_ram_we", {31'd0, r_we}, 32'd1);
    chk("rd_ack_cycle", r_ack_cyc, 3);
    chk("rd_ack_who", r_who, 1);
    chk("rd_q1", {24'd0, r_q}, 32'h5A);
    chk("rd_q0_hold", {24'd0, q0}, 32'h00);

    // Round-robin contention, last grant was requester 1.
    we0 = 1; a0 = 14'h0010; d0 = 8'h10;
    we1 = 1; a1 = 14'h0020; d1 = 8'h20;
    req0 = 1; req1 = 1;
    ng = 0; both = 0; wide = 0; p0 = 0; p1 = 0;
    for (int n = 0; n < 60 && ng < 4; n++) begin
      @(negedge clock);
      if (ack0 && ack1) both++;
      if ((ack0 && p0) || (ack1 && p1)) wide++;
      p0 = ack0; p1 = ack1;
      if (ack0) begin seq[ng] = 0; ng++; req0 = 0; end
      else if (!req0) req0 = 1;
      if (ack1) begin seq[ng] = 1; ng++; req1 = 0; end
      else if (!req1) req1 = 1;
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clock);
    chk("rr_grants", ng, 4);
    chk("rr_g0", seq[0], 0);
    chk("rr_g1", seq[1], 1);
    chk("rr_g2", seq[2], 0);
    chk("rr_g3", seq[3], 1);
    chk("rr_both_acks", both, 0);
    chk("rr_wide_ack", wide, 0);

    // Address boundaries.
    xfer(0, 1'b1, 14'h0000, 8'h11);
    chk("bnd_wr0_a", {18'd0, r_a}, 32'h0000);
    xfer(0, 1'b1, 14'h3FFF, 8'hFF);
    chk("bnd_wr3fff_a", {18'd0, r_a}, 32'h3FFF);
    chk("bnd_wr3fff_di", {24'd0, r_di}, 32'hFF);
    xfer(1, 1'b0, 14'h3FFF, 8'h00);
    chk("bnd_rd3fff_q", {24'd0, r_q}, 32'hFF);
    xfer(1, 1'b0, 14'h0000, 8'h00);
    chk("bnd_rd0_a", {18'd0, r_a}, 32'h0000);
    chk("bnd_rd0_q", {24'd0, r_q}, 32'h11);

    // Fixed priority instance: requester 0 keeps re-requesting.
    f_req0 = 1; f_req1 = 1;
    n0 = 0; a1cnt = 0; lat = 0;
    for (int n = 0; n < 80 && n0 < 4; n++) begin
      @(negedge clock);
      if (f_ack1) a1cnt++;
      if (f_ack0) begin n0++; f_req0 = 0; end
      else if (!f_req0) f_req0 = 1;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (f_ack1) begin lat = k; break; end
    end
    f_req1 = 0;
    repeat (2) @(negedge clock);
    chk("fx_req0_grants", n0, 4);
    chk("fx_req1_starved", a1cnt, 0);
    chk("fx_req1_latency", lat, 3);

    // Reset asserted during RD of a read from requester 1.
    req1 = 1; we1 = 0; a1 = 14'h3FFF;
    @(negedge clock);
    chk("mrst_acc_ce", {31'd0, ram_ce}, 32'd1);
    @(negedge clock);
    chk("mrst_rd_busy", {31'd0, busy}, 32'd1);
    reset = 0; req1 = 0;
    #1;
    chk("mrst_ce", {31'd0, ram_ce}, 32'd0);
    chk("mrst_ack1", {31'd0, ack1}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_q1", {24'd0, q1}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (ack0 || ack1 || busy || ram_ce) bad++;
    end
    chk("mrst_quiet", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
